// File: rtl/flit_assembler_std.sv
// Collects the flits of one NoC packet into a single wide word for the depacketizer.
// Malformed flit sequences are discarded and flagged with a one-cycle err_drop pulse.
module flit_assembler_std #(
  parameter int WIDTH_FLIT       = 36,
  parameter int NUM_FLITS        = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_PKT        = WIDTH_FLIT * NUM_FLITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_FLIT-1:0]       flit_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [WIDTH_PKT-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        err_drop,
  output logic [1:0]                  dbg_state,
  output logic [VC_ADDRESS_WIDTH-1:0] dbg_vc
);

  localparam int CNT_W = $clog2(NUM_FLITS + 1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_FLITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_nstate;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_ncnt;
  logic [WIDTH_PKT-1:0]        r_buf;
  logic [WIDTH_PKT-1:0]        w_nbuf;
  logic [WIDTH_PKT-1:0]        w_head_buf;
  logic                        r_complete;
  logic [WIDTH_PKT-1:0]        r_data_out;
  logic                        r_valid_out;
  logic                        r_err;
  logic [VC_ADDRESS_WIDTH-1:0] r_vc;
  logic                        w_accept;
  logic                        w_out_free;
  logic                        w_head;
  logic                        w_tail;
  logic                        w_done;
  logic                        w_err;

  // Both sides use valid/ready: a word moves on the edge where valid && ready
  // are both high; a sender holds its data stable until that edge.
  assign w_accept   = valid_in && !r_complete;
  assign w_out_free = !r_valid_out || ready_in;
  assign w_head     = flit_in[WIDTH_FLIT-1];
  assign w_tail     = flit_in[WIDTH_FLIT-2];

  assign ready_out  = !r_complete;
  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign err_drop   = r_err;
  assign dbg_state  = r_state;
  assign dbg_vc     = r_vc;

  always_comb begin
    w_head_buf = '0;
    w_head_buf[WIDTH_PKT-1 -: WIDTH_FLIT] = flit_in;
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nbuf   = r_buf;
    w_done   = 1'b0;
    w_err    = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (!w_head) begin
            w_err = 1'b1;
          end else if (w_tail) begin
            w_nbuf = w_head_buf;
            w_done = 1'b1;
          end else if (NUM_FLITS == 1) begin
            w_err = 1'b1;
          end else begin
            w_nbuf   = w_head_buf;
            w_ncnt   = CNT_W'(1);
            w_nstate = ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (w_head) begin
            // A new head abandons the partial packet and restarts in slot 0.
            w_err  = 1'b1;
            w_nbuf = w_head_buf;
            if (w_tail) begin
              w_done   = 1'b1;
              w_ncnt   = '0;
              w_nstate = IDLE;
            end else begin
              w_ncnt   = CNT_W'(1);
              w_nstate = ASSEMBLE;
            end
          end else begin
            for (int k = 0; k < NUM_FLITS; k++) begin
              if (CNT_W'(k) == r_cnt)
                w_nbuf[WIDTH_PKT-1-k*WIDTH_FLIT -: WIDTH_FLIT] = flit_in;
            end
            if (w_tail) begin
              w_done   = 1'b1;
              w_ncnt   = '0;
              w_nstate = IDLE;
            end else if (r_cnt == LAST_SLOT) begin
              w_err    = 1'b1;
              w_ncnt   = '0;
              w_nstate = DROP;
            end else begin
              w_ncnt = r_cnt + CNT_W'(1);
            end
          end
        end
        DROP: begin
          if (w_tail) begin
            w_nstate = IDLE;
          end else if (w_head) begin
            w_nbuf   = w_head_buf;
            w_ncnt   = CNT_W'(1);
            w_nstate = ASSEMBLE;
          end
        end
        default: begin
          w_ncnt   = '0;
          w_nstate = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_err   <= 1'b0;
      r_vc    <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_buf   <= w_nbuf;
      r_err   <= w_err;
      if (w_accept && w_head)
        r_vc <= flit_in[WIDTH_FLIT-3 -: VC_ADDRESS_WIDTH];
    end
  end

  // A finished packet goes straight to the output when it is free; otherwise
  // it waits in r_buf with input stalled until the output drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_complete  <= 1'b0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else if (w_done) begin
      if (w_out_free) begin
        r_data_out  <= w_nbuf;
        r_valid_out <= 1'b1;
      end else begin
        r_complete  <= 1'b1;
      end
    end else if (r_complete && w_out_free) begin
      r_data_out  <= r_buf;
      r_valid_out <= 1'b1;
      r_complete  <= 1'b0;
    end else if (r_valid_out && ready_in) begin
      r_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flit_assembler_std.sv
// Directed bench for flit_assembler_std: hand-built packets, a scoreboard on the
// output handshake, and targeted checks of timing, stalls and error pulses.
module tb_flit_assembler_std;

  localparam int WF = 36;
  localparam int NF = 4;
  localparam int WP = WF * NF;

  logic          clk;
  logic          rst;
  logic [WF-1:0] flit_in;
  logic          valid_in;
  logic          ready_out;
  logic [WP-1:0] data_out;
  logic          valid_out;
  logic          ready_in;
  logic          err_drop;
  logic [1:0]    dbg_state;
  logic [0:0]    dbg_vc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int n_extra  = 0;
  int n_exp    = 0;

  logic [WP-1:0] exp_q[$];

  flit_assembler_std #(
    .WIDTH_FLIT(WF), .NUM_FLITS(NF), .VC_ADDRESS_WIDTH(1)
  ) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .err_drop(err_drop), .dbg_state(dbg_state),
    .dbg_vc(dbg_vc)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [WP-1:0] obs, input logic [WP-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WF-1:0] mk(input logic h, input logic t, input logic [WF-4:0] pl);
    return {h, t, 1'b0, pl};
  endfunction

  function automatic logic [WP-1:0] pk(input logic [WF-1:0] f0, input logic [WF-1:0] f1,
                                       input logic [WF-1:0] f2, input logic [WF-1:0] f3);
    return {f0, f1, f2, f3};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WF-1:0] f);
    flit_in  = f;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    flit_in  = '0;
  endtask

  task automatic expect_pkt(input logic [WP-1:0] p);
    exp_q.push_back(p);
    n_exp++;
  endtask

  // scoreboard on the output handshake
  always @(negedge clk) begin
    if (rst && valid_out && ready_in) begin
      n_deliv++;
      if (exp_q.size() > 0) check("pkt_data", data_out, exp_q.pop_front());
      else n_extra++;
    end
  end

  logic [WP-1:0] p41;
  logic [WP-1:0] p42;
  int            base;

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    flit_in  = '0;
    ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid_out", WP'(valid_out), WP'(0));
    check("rst_ready_out", WP'(ready_out), WP'(1));
    check("rst_err_drop",  WP'(err_drop),  WP'(0));
    check("rst_data_out",  data_out,       '0);
    check("rst_state",     WP'(dbg_state), WP'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // 4-flit packet, valid_out one cycle after the tail
    expect_pkt(pk(mk(1, 0, 33'hA), mk(0, 0, 33'hB), mk(0, 0, 33'hC), mk(0, 1, 33'hD)));
    send(mk(1, 0, 33'hA));
    send(mk(0, 0, 33'hB));
    send(mk(0, 0, 33'hC));
    check("p4_not_early", WP'(valid_out), WP'(0));
    send(mk(0, 1, 33'hD));
    check("p4_valid", WP'(valid_out), WP'(1));
    check("p4_data", data_out, pk(mk(1, 0, 33'hA), mk(0, 0, 33'hB), mk(0, 0, 33'hC), mk(0, 1, 33'hD)));

    // 2-flit packet then head+tail back to back
    expect_pkt(pk(mk(1, 0, 33'h11), mk(0, 1, 33'h22), '0, '0));
    expect_pkt(pk(mk(1, 1, 33'h33), '0, '0, '0));
    send(mk(1, 0, 33'h11));
    send(mk(0, 1, 33'h22));
    check("p2_data", data_out, pk(mk(1, 0, 33'h11), mk(0, 1, 33'h22), '0, '0));
    send(mk(1, 1, 33'h33));
    check("p1_next_valid", WP'(valid_out), WP'(1));
    check("p1_next_data", data_out, pk(mk(1, 1, 33'h33), '0, '0, '0));
    step();

    // backpressure: two single-flit packets while ready_in is low
    p41 = pk(mk(1, 1, 33'h41), '0, '0, '0);
    p42 = pk(mk(1, 1, 33'h42), '0, '0, '0);
    expect_pkt(p41);
    expect_pkt(p42);
    ready_in = 1'b0;
    send(mk(1, 1, 33'h41));
    check("bp_first_valid", WP'(valid_out), WP'(1));
    check("bp_ready_still", WP'(ready_out), WP'(1));
    send(mk(1, 1, 33'h42));
    check("bp_stall", WP'(ready_out), WP'(0));
    check("bp_hold_data", data_out, p41);
    step();
    check("bp_hold_data2", data_out, p41);
    ready_in = 1'b1;
    step();
    check("bp_second_data", data_out, p42);
    check("bp_ready_back", WP'(ready_out), WP'(1));
    step();
    check("bp_drained", WP'(valid_out), WP'(0));

    // body flit without a head in IDLE
    base = n_deliv;
    send(mk(0, 0, 33'h60));
    check("err_nohead", WP'(err_drop), WP'(1));
    check("err_nohead_noout", WP'(valid_out), WP'(0));
    step();
    check("err_pulse_short", WP'(err_drop), WP'(0));

    // overlong packet: overflow at the 4th flit, rest discarded up to the tail
    send(mk(1, 0, 33'h61));
    send(mk(0, 0, 33'h62));
    send(mk(0, 0, 33'h63));
    check("ovf_no_err_yet", WP'(err_drop), WP'(0));
    send(mk(0, 0, 33'h64));
    check("ovf_err", WP'(err_drop), WP'(1));
    check("ovf_state_drop", WP'(dbg_state), WP'(2));
    send(mk(0, 0, 33'h65));
    send(mk(0, 1, 33'h66));
    check("ovf_state_idle", WP'(dbg_state), WP'(0));
    step();
    check("ovf_no_output", WP'(n_deliv - base), WP'(0));
    expect_pkt(pk(mk(1, 0, 33'h67), mk(0, 1, 33'h68), '0, '0));
    send(mk(1, 0, 33'h67));
    send(mk(0, 1, 33'h68));
    check("ovf_recover", data_out, pk(mk(1, 0, 33'h67), mk(0, 1, 33'h68), '0, '0));
    step();

    // new head+tail mid-assembly restarts in slot 0
    expect_pkt(pk(mk(1, 1, 33'h55), '0, '0, '0));
    send(mk(1, 0, 33'h50));
    send(mk(0, 0, 33'h51));
    send(mk(1, 1, 33'h55));
    check("restart_err", WP'(err_drop), WP'(1));
    check("restart_valid", WP'(valid_out), WP'(1));
    check("restart_data", data_out, pk(mk(1, 1, 33'h55), '0, '0, '0));
    step();

    // reset mid-assembly while a packet sits on the output
    ready_in = 1'b0;
    send(mk(1, 1, 33'h70));
    send(mk(1, 0, 33'h71));
    send(mk(0, 0, 33'h72));
    check("pre_rst_state", WP'(dbg_state), WP'(1));
    check("pre_rst_valid", WP'(valid_out), WP'(1));
    rst = 1'b0;
    #2;
    check("mid_rst_valid", WP'(valid_out), WP'(0));
    check("mid_rst_ready", WP'(ready_out), WP'(1));
    check("mid_rst_state", WP'(dbg_state), WP'(0));
    @(posedge clk);
    #1;
    rst      = 1'b1;
    ready_in = 1'b1;
    send(mk(0, 1, 33'h73));
    check("post_rst_tail_err", WP'(err_drop), WP'(1));
    check("post_rst_no_out", WP'(valid_out), WP'(0));
    expect_pkt(pk(mk(1, 1, 33'h74), '0, '0, '0));
    send(mk(1, 1, 33'h74));
    check("post_rst_good", data_out, pk(mk(1, 1, 33'h74), '0, '0, '0));
    repeat (3) step();

    check("pkts_delivered", WP'(n_deliv), WP'(n_exp));
    check("pkts_extra", WP'(n_extra), WP'(0));
    check("exp_q_empty", WP'(exp_q.size()), WP'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_assembler_std.md
Name: flit_assembler_std

Overview:
- Sits directly upstream of the standard depacketizer, between a NoC router output port and the depacketizer's packet input.
- Receives one flit per cycle, strips nothing, and assembles the flits of one packet into a WIDTH_PKT-wide word for the depacketizer.
- Handles packets of 1..NUM_FLITS flits, zero-fills unused flit slots, and discards malformed flit sequences with an error pulse.

Parameters:
- WIDTH_FLIT, 36, total flit width including header bits
- NUM_FLITS, 4, maximum flits per packet; matches DEPACKETIZER_WIDTH downstream (1, 2 or 4)
- VC_ADDRESS_WIDTH, 1, VC id field width carried in each flit
- WIDTH_PKT, WIDTH_FLIT*NUM_FLITS, assembled packet width

Ports:
- clk  in  1  single clock
- rst  in  1  reset; asynchronous assert, active-low
- flit_in  in  WIDTH_FLIT  flit; [W-1]=head, [W-2]=tail, [W-3 -: VC_ADDRESS_WIDTH]=vc, remainder payload
- valid_in  in  1  flit_in valid
- ready_out  out  1  assembler can accept a flit this cycle
- data_out  out  WIDTH_PKT  assembled packet; flit k at [WIDTH_PKT-1-k*WIDTH_FLIT -: WIDTH_FLIT]
- valid_out  out  1  data_out valid
- ready_in  in  1  downstream accepts data_out
- err_drop  out  1  one-cycle pulse when a flit or partial packet is discarded

Behaviour:
- Reset values (async, rst=0): state=IDLE, flit count=0, assembly buffer=0, complete=0, data_out=0, valid_out=0, err_drop=0. Mid-packet reset discards everything; no output is produced for the partial packet.
- A flit transfers on valid_in && ready_out. ready_out = !complete (registered flag).
- Output register: loaded on the same edge that accepts a tail if (!valid_out || ready_in). Otherwise the buffer sets complete=1, which stalls input until the buffer moves to the output register on the first cycle with (!valid_out || ready_in).
- valid_out clears on valid_out && ready_in unless reloaded that edge. data_out is stable while valid_out && !ready_in.
- Latency: tail accepted at edge T gives valid_out=1 after T when the output is free. Back-to-back single-flit packets sustain 1 packet/cycle with ready_in=1.
- IDLE:
  - head&tail: load slot 0, other slots 0, complete the packet.
  - head&!tail: load slot 0, cnt=1, go to ASSEMBLE.
  - non-head flit: drop it, err_drop=1, stay IDLE.
- ASSEMBLE:
  - non-head flit goes to slot cnt, cnt++.
  - On tail: complete the packet, clear unwritten slots to 0, cnt=0, go to IDLE.
  - cnt reaches NUM_FLITS without a tail: go to DROP, err_drop=1, partial packet discarded.
  - Head flit arrives: err_drop=1, partial packet discarded, the new head restarts assembly in slot 0 (same edge; head&tail completes immediately).
- DROP: accept and discard flits until a tail; a head+tail in DROP is also discarded. Then go to IDLE. A head without tail in DROP restarts in ASSEMBLE.
- Flit bits are copied to slots unmodified (headers retained for the depacketizer).
- NUM_FLITS=1: every accepted flit without both head and tail set is dropped with err_drop=1.
- cnt width is $clog2(NUM_FLITS+1). The slot index never exceeds NUM_FLITS-1.

Test Plan:
- NUM_FLITS=4, ready_in=1; 4-flit packet, payloads 0xA,0xB,0xC,0xD, head on first, tail on last -> one valid_out, slots 0..3 = the four flits in order, valid_out 1 cycle after the tail.
- 2-flit packet (0x11 head, 0x22 tail) -> slots 0,1 hold the flits, slots 2,3 = 0; immediately followed by a head+tail 0x33 -> second packet on the very next cycle, slot 0 = 0x33.
- ready_in=0 held; send two complete 1-flit packets -> first held on data_out, second completes, ready_out drops to 0. Raise ready_in -> both delivered in order, no loss; ready_out returns to 1.
- Body flit with no head in IDLE -> err_drop pulse, no valid_out. Then head,body,body,body,body (5 flits, no tail) then tail -> err_drop at the 4th flit boundary, no output; the next good packet assembles correctly.
- Head,body, then new head+tail 0x55 -> err_drop=1 on that edge, output packet slot 0 = 0x55, others 0.
- Assert rst low mid-ASSEMBLE with valid_out=1 -> valid_out=0, ready_out=1 after release; the trailing tail flit is dropped with err_drop.
